// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding control block.
// Holds the register-zero constant, the destination-tag struct carried
// through MEM/WB, the extended EX tag that also carries the source
// operands, and the tag-match function used by both operand paths.
package hazard_pkg;

   localparam int unsigned TAG_AW = 5;
   localparam logic [TAG_AW-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic              valid;
      logic [TAG_AW-1:0] rd;
      logic              reg_write;
      logic              is_load;
   } dst_tag_t;

   typedef struct packed {
      dst_tag_t          dst;
      logic [TAG_AW-1:0] rs1;
      logic [TAG_AW-1:0] rs2;
      logic              use_rs1;
      logic              use_rs2;
   } ex_tag_t;

   // True when an older stage will write the register this operand reads.
   // x0 never matches because its value is architecturally fixed.
   function automatic logic fwd_match(input dst_tag_t          tag,
                                      input logic [TAG_AW-1:0] rs,
                                      input logic              use_rs);
      return use_rs & tag.valid & tag.reg_write &
             (tag.rd != REG_ZERO) & (tag.rd == rs);
   endfunction

endpackage

// File: rtl/hazard_forward_unit_sat_counter.sv
// Saturating event counter.
// Ports: clk, rst_n (sync active-low), inc_i (count this cycle),
//        count_o (registered count, holds at all-ones).
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   localparam logic [W-1:0] CNT_MAX = '1;

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: step by one unless already at the ceiling.
   always_comb begin
      if (inc_i && (count_q != CNT_MAX)) begin
         count_d = count_q + {{(W-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // Count register, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding-select control for a 5-stage pipeline.
// Tracks destination tags through EX, MEM and WB, raises a load-use
// stall, and drives the Sel inputs of the two chained 2:1 operand muxes
// (first mux: regfile vs WB result; second mux: first-mux vs MEM result).
// Ports: clk, rst_n (sync active-low); ID-stage instruction fields
//        id_*; flush (taken branch in EX); stall; fwd_{a,b}_{wb,mem};
//        stall_count (saturating stall-cycle count).
module hazard_forward_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW = TAG_AW,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_is_load,
   input  logic              flush,
   output logic              stall,
   output logic              fwd_a_wb,
   output logic              fwd_a_mem,
   output logic              fwd_b_wb,
   output logic              fwd_b_mem,
   output logic [CNT_W-1:0]  stall_count
);

   ex_tag_t  ex_q;
   ex_tag_t  ex_d;
   dst_tag_t mem_q;
   dst_tag_t wb_q;

   logic src_hit_s;
   logic stall_s;

   // Load-use detection: the ID instruction needs a value a load in EX
   // has not produced yet. A taken branch kills ID, so no stall then.
   always_comb begin
      src_hit_s = (id_use_rs1 && (id_rs1 == ex_q.dst.rd)) ||
                  (id_use_rs2 && (id_rs2 == ex_q.dst.rd));
      if (flush) begin
         stall_s = 1'b0;
      end else begin
         stall_s = id_valid & ex_q.dst.valid & ex_q.dst.is_load &
                   ex_q.dst.reg_write & (ex_q.dst.rd != REG_ZERO) & src_hit_s;
      end
   end

   // Next EX tag: the ID instruction, turned into a bubble on stall or flush.
   always_comb begin
      ex_d               = '0;
      ex_d.dst.valid     = id_valid & ~stall_s & ~flush;
      ex_d.dst.rd        = id_rd;
      ex_d.dst.reg_write = id_reg_write;
      ex_d.dst.is_load   = id_is_load;
      ex_d.rs1           = id_rs1;
      ex_d.rs2           = id_rs2;
      ex_d.use_rs1       = id_use_rs1;
      ex_d.use_rs2       = id_use_rs2;
   end

   // Tag pipeline: EX -> MEM -> WB advances every cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= ex_q.dst;
         wb_q  <= mem_q;
      end
   end

   // Forwarding selects from registered tags only. A load in MEM has no
   // result yet; the stall guarantees such a case never needs forwarding.
   // WB is evaluated on its own: the second mux gives MEM precedence.
   always_comb begin
      fwd_a_mem = ex_q.dst.valid & ~mem_q.is_load & fwd_match(mem_q, ex_q.rs1, ex_q.use_rs1);
      fwd_b_mem = ex_q.dst.valid & ~mem_q.is_load & fwd_match(mem_q, ex_q.rs2, ex_q.use_rs2);
      fwd_a_wb  = ex_q.dst.valid & fwd_match(wb_q, ex_q.rs1, ex_q.use_rs1);
      fwd_b_wb  = ex_q.dst.valid & fwd_match(wb_q, ex_q.rs2, ex_q.use_rs2);
   end

   assign stall = stall_s;

   sat_counter #(
      .W(CNT_W)
   ) u_stall_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (stall_s),
      .count_o (stall_count)
   );

endmodule
